// File: rtl/ahb_arb2_s1_pkg.sv
// Shared definitions for the two-master AHB-Lite arbiter in front of slave s1.
// Holds the HTRANS encodings, the per-master state encoding and the packed
// address-phase record that the hold slots capture.
package ahb_arb2_s1_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    MST_IDLE = 2'b00,  // nothing outstanding, hready high
    MST_PEND = 2'b01,  // address captured, waiting for an issue slot
    MST_DATA = 2'b10   // owns the s1 data phase
  } mst_state_e;

  // Address-phase control captured for a held transfer. HTRANS is not kept:
  // a held transfer is always reissued as NONSEQ.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              write;
  } addr_ph_t;

  localparam int ADDR_PH_W = $bits(addr_ph_t);

endpackage

// File: rtl/ahb_arb2_s1_pend.sv
// Per-master hold slot: captures an address phase that cannot issue at once,
// tracks IDLE/PEND/DATA for that master and generates its hready.
module ahb_arb_pend_slot
  import ahb_arb2_s1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hready_s1_i,
  input  logic                 win_i,        // this master issues to s1 this cycle
  input  logic                 trans_act_i,  // htrans[1]: NONSEQ or SEQ
  input  logic [ADDR_PH_W-1:0] req_i,        // live address-phase fields
  output logic                 live_o,
  output logic                 pend_o,
  output logic                 hready_o,
  output logic [ADDR_PH_W-1:0] hold_o
);

  mst_state_e           state_q;
  logic [ADDR_PH_W-1:0] hold_q;

  // hready: free when idle, stalled while held, follows the slave in data phase.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    hready_o = 1'b1;
    case (state_q)
      MST_PEND: hready_o = 1'b0;
      MST_DATA: hready_o = hready_s1_i;
      default:  hready_o = 1'b1;
    endcase
  end

  // A request is live only while the master sees hready high; reset blocks it
  // so nothing reaches s1 while the arbiter is held in reset.
  assign live_o = trans_act_i & hready_o & ~rst;
  assign pend_o = (state_q == MST_PEND);
  assign hold_o = hold_q;

  // Master state machine and hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the hold slot is a handful of flops, not a memory, so it is cleared on reset like any state.
      state_q <= MST_IDLE;
      hold_q  <= '0;
    end else if (win_i) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state_q <= MST_DATA;
    end else if (live_o) begin
      state_q <= MST_PEND;
      hold_q  <= req_i;
    end else if (state_q == MST_DATA && hready_s1_i) begin
      state_q <= MST_IDLE;
    end
  end

endmodule

// File: rtl/ahb_arb2_s1.sv
// Two-master AHB-Lite arbiter for memory-controller slave port s1.
// m0 = CPU, m1 = loader/debug. One transfer issues per cycle; the loser or a
// request arriving during a slave wait is held and reissued as NONSEQ.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise m0
// has fixed priority.
module ahb_arb2_s1
  import ahb_arb2_s1_pkg::*;
(
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  input  logic [31:0] haddr_m0,
  input  logic [1:0]  htrans_m0,
  input  logic [2:0]  hsize_m0,
  input  logic [2:0]  hburst_m0,
  input  logic [3:0]  hprot_m0,
  input  logic        hwrite_m0,
  input  logic [31:0] hwdata_m0,
  input  logic [31:0] haddr_m1,
  input  logic [1:0]  htrans_m1,
  input  logic [2:0]  hsize_m1,
  input  logic [2:0]  hburst_m1,
  input  logic [3:0]  hprot_m1,
  input  logic        hwrite_m1,
  input  logic [31:0] hwdata_m1,
  output logic        hready_m0,
  output logic        hready_m1,
  output logic [31:0] hrdata_m,
  output logic [1:0]  hresp_m,
  output logic [31:0] haddr_s1,
  output logic [1:0]  htrans_s1,
  output logic [2:0]  hsize_s1,
  output logic [2:0]  hburst_s1,
  output logic [3:0]  hprot_s1,
  output logic        hwrite_s1,
  output logic [31:0] hwdata_s1,
  output logic        hsel_s1,
  input  logic [31:0] hrdata_s1,
  input  logic        hready_s1,
  input  logic [1:0]  hresp_s1
);

  logic     live0, live1, pend0, pend1;
  logic     win0, win1, issue, from_pend;
  logic     cand0, cand1;
  logic [1:0] sel_trans_d;
  addr_ph_t live_ph0, live_ph1, hold0, hold1;
  addr_ph_t sel_d, last_q;
  logic     dph_vld_q, dph_mst_q;

  assign live_ph0 = {haddr_m0, hsize_m0, hburst_m0, hprot_m0, hwrite_m0};
  assign live_ph1 = {haddr_m1, hsize_m1, hburst_m1, hprot_m1, hwrite_m1};

  ahb_arb_pend_slot u_slot0 (
    .clk         (pll_core_cpuclk),
    .rst         (pad_cpu_rst),
    .hready_s1_i (hready_s1),
    .win_i       (win0),
    .trans_act_i (htrans_m0[1]),
    .req_i       (live_ph0),
    .live_o      (live0),
    .pend_o      (pend0),
    .hready_o    (hready_m0),
    .hold_o      (hold0)
  );

  ahb_arb_pend_slot u_slot1 (
    .clk         (pll_core_cpuclk),
    .rst         (pad_cpu_rst),
    .hready_s1_i (hready_s1),
    .win_i       (win1),
    .trans_act_i (htrans_m1[1]),
    .req_i       (live_ph1),
    .live_o      (live1),
    .pend_o      (pend1),
    .hready_o    (hready_m1),
    .hold_o      (hold1)
  );

`ifdef ARB_RR_EN
  logic last_win_q;  // 1: m1 issued most recently

  // Round-robin: on contention the master that did not issue last wins.
  always_comb begin
    cand0 = hready_s1 & (pend0 | live0);
    cand1 = hready_s1 & (pend1 | live1);
    win0  = cand0;
    win1  = cand1;
    if (cand0 && cand1) begin
      win0 = last_win_q;
      win1 = ~last_win_q;
    end
  end

  // Remember the last issuing master; m1 after reset so m0 wins first.
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      last_win_q <= 1'b1;
    end else if (win0 || win1) begin
      last_win_q <= win1;
    end
  end
`else
  // Fixed priority: m0 always wins; m1 may starve under continuous m0 traffic.
  always_comb begin
    cand0 = hready_s1 & (pend0 | live0);
    cand1 = hready_s1 & (pend1 | live1);
    win0  = cand0;
    win1  = cand1 & ~cand0;
  end
`endif

  assign issue = win0 | win1;

  // Pick the winner's fields: held copy (forced NONSEQ) or the live bus.
  always_comb begin
    from_pend   = win1 ? pend1 : pend0;
    sel_d       = win1 ? (pend1 ? hold1 : live_ph1) : (pend0 ? hold0 : live_ph0);
    sel_trans_d = from_pend ? HTRANS_NONSEQ : (win1 ? htrans_m1 : htrans_m0);
  end

  // s1 request mux: winner when issuing, otherwise IDLE with the last fields held.
  always_comb begin
    hsel_s1   = issue;
    htrans_s1 = issue ? sel_trans_d : HTRANS_IDLE;
    {haddr_s1, hsize_s1, hburst_s1, hprot_s1, hwrite_s1} = issue ? sel_d : last_q;
  end

  // Data-phase owner and last-issued fields advance only when s1 is ready.
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      dph_vld_q <= 1'b0;
      dph_mst_q <= 1'b0;
      last_q    <= '0;
    end else if (hready_s1) begin
      dph_vld_q <= issue;
      dph_mst_q <= win1;
      if (issue) begin
        last_q <= sel_d;
      end
    end
  end

  assign hwdata_s1 = !dph_vld_q ? '0 : (dph_mst_q ? hwdata_m1 : hwdata_m0);
  assign hrdata_m  = hrdata_s1;
  assign hresp_m   = hresp_s1;

endmodule
